shift_seq_ctrl: RTL and testbench
=================================

# shift_seq_ctrl

Command sequencer that sits directly upstream of the team's 64-bit load/shift register (ports `load`, `ena`, `amount[1:0]`, `data[63:0]`). It accepts one command at a time over a valid/ready handshake: either "load a 64-bit word" or "shift by N bits (0–63) left-logical or right-arithmetic". It breaks each shift into the shifter's native steps (by 8 and by 1), drives the shifter's control pins cycle by cycle, and pulses `done` when the command has fully taken effect.

## Interface
- `DATA_W`, 64: width of load data; fixed to the shifter width.
- `CNT_W`, 6: width of the shift count; maximum shift is 2^CNT_W−1.

- `clk`  in  1: single clock; all state changes on the rising edge.
- `areset`  in  1: asynchronous, active-high reset.
- `cmd_valid`  in  1: a command is presented.
- `cmd_ready`  out  1: the block can accept a command; high only in IDLE.
- `cmd_load`  in  1: 1 = load command, 0 = shift command.
- `cmd_dir`  in  1: shift direction; 0 = left logical, 1 = right arithmetic. Ignored on load.
- `cmd_count`  in  CNT_W: number of bit positions to shift. Ignored on load.
- `cmd_data`  in  DATA_W: word to load. Ignored on shift.
- `load`  out  1: to shifter; high for exactly one cycle per load command.
- `ena`  out  1: to shifter; high on each shift step.
- `amount`  out  2: to shifter; 00 = <<1, 01 = <<8, 10 = >>>1, 11 = >>>8.
- `data`  out  DATA_W: to shifter; the held load word.
- `busy`  out  1: a command is in progress (not IDLE).
- `done`  out  1: one-cycle pulse after the last `load`/`ena` cycle of a command.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: `cmd_ready`=1. When `cmd_valid`&&`cmd_ready` at an edge, the block latches `cmd_data`, `cmd_dir`, and `cmd_count` into `rem`:
  - `cmd_load`=1: go to LOAD.
  - `cmd_load`=0 and `cmd_count`≠0: go to SHIFT.
  - `cmd_load`=0 and `cmd_count`=0: go to DONE. No shifter activity.
- LOAD: `load`=1 and `data`=latched word for one cycle; then go to DONE.
- SHIFT: `ena`=1 every cycle.
  - If `rem`≥8: step is 8, `amount`={dir,1}, `rem`−=8.
  - Otherwise: step is 1, `amount`={dir,0}, `rem`−=1.
  - Leave for DONE on the cycle `rem` becomes 0.
  - Number of SHIFT cycles = `count`/8 + `count`%8.
- DONE: `done`=1 for one cycle; then go to IDLE.
- Output rules:
  - Outputs are Moore: decoded from the state register and `rem`.
  - `load` and `ena` are never high in the same cycle.
  - `ena`=0 outside SHIFT and `load`=0 outside LOAD.
  - `amount` is 00 outside SHIFT.
  - `data` holds the last latched word at all times.
- `cmd_valid` seen while `cmd_ready`=0 is not consumed. The upstream holds the command until it is accepted.
- Reset: asynchronous. Immediately forces IDLE, `rem`=0, `data`=0, `dir`=0, and all outputs to 0 except `cmd_ready`=1. Reset in mid-command abandons the command with no `done`; the shifter keeps any steps already applied.

## Timing
- Command accepted at edge T.
- Load: `load` high in cycle T..T+1, `done` high in T+1..T+2, `cmd_ready` high again from T+2.
- Shift by N>0: `ena` high for S = N/8 + N%8 consecutive cycles starting at T; `done` in the cycle after the last `ena`; `cmd_ready` one cycle after that. Total occupancy is S+2 cycles.
- Shift by 0: `done` high in T..T+1.
- Throughput: no back-to-back overlap. The next command is accepted no earlier than the edge ending the DONE cycle.

## Structure
- Shared package `shift_pkg` holds:
  - the `amount` encodings as named constants (SHL1, SHL8, SAR1, SAR8);
  - the state enum;
  - `DATA_W` and `CNT_W` defaults.
- No sub-module. Step selection is a few lines of logic inside the FSM.
- The top-level test harness instantiates this block feeding the shifter, with a reference model in the bench.

## Test plan
- Load then shift: load `0x8000_0000_0000_0001`, then shift right by 9 → one `load` pulse; `ena` for 2 cycles with `amount` 11 then 10; shifter q=`0xFFC0_0000_0000_0000`; `done` once per command.
- Shift left by 19: from q=1 → `ena` for 5 cycles with `amount` 01,01,00,00,00; q=`0x80000`; `done` exactly 1 cycle after the last `ena`.
- Boundary counts: count=0 → `done` only, no `ena`. Count=63 left from q=1 → 14 `ena` cycles, q=`0x8000_0000_0000_0000`. Count=8 → a single `ena` with `amount`=01.
- Handshake: hold `cmd_valid` high with a new command during busy → `cmd_ready`=0 and the command is not consumed until after DONE; accepted on the edge `cmd_ready` is seen high; no command lost or duplicated.
- Reset mid-shift: assert `areset` during the 3rd `ena` cycle of a count-40 shift → `ena`, `amount`, `busy`, and `done` drop to 0 asynchronously; `cmd_ready`=1 after release; no `done` pulse for the aborted command.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift-register command sequencer:
// shifter step encodings, FSM states and default widths.
package shift_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_CNT_W  = 6;

    // Control encodings understood by the downstream load/shift register
    localparam logic [1:0] SHL1 = 2'b00;
    localparam logic [1:0] SHL8 = 2'b01;
    localparam logic [1:0] SAR1 = 2'b10;
    localparam logic [1:0] SAR8 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/shift_seq_ctrl.sv
// Sequences load / shift commands onto a 64-bit load-shift register,
// splitting each shift into by-8 and by-1 steps; one command in flight at a time.
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic              cmd_dir,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              load,
    output logic              ena,
    output logic [1:0]        amount,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] BIG_STEP = CNT_W'(8);
    localparam logic [CNT_W-1:0] ONE_STEP = CNT_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  rem;
    logic [CNT_W-1:0]  rem_step;
    logic              dir;
    logic              big;
    logic              accept;

    assign accept   = (state == ST_IDLE) && cmd_valid;
    assign big      = (rem >= BIG_STEP);
    assign rem_step = big ? (rem - BIG_STEP) : (rem - ONE_STEP);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_load)
                        state_nxt = ST_LOAD;
                    else if (cmd_count != '0)
                        state_nxt = ST_SHIFT;
                    else
                        state_nxt = ST_DONE;
                end
            end
            ST_LOAD:  state_nxt = ST_DONE;
            // Leave on the step that drains the remaining count
            ST_SHIFT: if (rem_step == '0) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            rem  <= '0;
            dir  <= 1'b0;
            data <= '0;
        end else if (accept) begin
            rem  <= cmd_count;
            dir  <= cmd_dir;
            data <= cmd_data;
        end else if (state == ST_SHIFT) begin
            rem  <= rem_step;
        end
    end

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        load      = 1'b0;
        ena       = 1'b0;
        amount    = SHL1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_LOAD:  load = 1'b1;
            ST_SHIFT: begin
                ena = 1'b1;
                case ({dir, big})
                    2'b00:   amount = SHL1;
                    2'b01:   amount = SHL8;
                    2'b10:   amount = SAR1;
                    default: amount = SAR8;
                endcase
            end
            ST_DONE:  done = 1'b1;
            default:  busy = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench: drives commands into shift_seq_ctrl feeding a behavioural
// load/shift register and checks pin sequences and resulting register values.
module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_load = 1'b0;
    logic        cmd_dir = 1'b0;
    logic [5:0]  cmd_count = '0;
    logic [63:0] cmd_data = '0;
    logic        load;
    logic        ena;
    logic [1:0]  amount;
    logic [63:0] data;
    logic        busy;
    logic        done;

    logic [63:0] q = '0;
    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    shift_seq_ctrl dut (
        .clk       (clk),
        .areset    (areset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_load  (cmd_load),
        .cmd_dir   (cmd_dir),
        .cmd_count (cmd_count),
        .cmd_data  (cmd_data),
        .load      (load),
        .ena       (ena),
        .amount    (amount),
        .data      (data),
        .busy      (busy),
        .done      (done)
    );

    // Behavioural model of the downstream shifter; it has no reset of its own
    always @(posedge clk) begin
        if (load) q <= data;
        else if (ena) begin
            case (amount)
                2'b00: q <= q << 1;
                2'b01: q <= q << 8;
                2'b10: q <= $signed(q) >>> 1;
                2'b11: q <= $signed(q) >>> 8;
                default: q <= q;
            endcase
        end
    end

    task automatic issue(input logic ld, input logic dr, input logic [5:0] cnt, input logic [63:0] d);
        int t = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = ld; cmd_dir = dr; cmd_count = cnt; cmd_data = d;
        while (cmd_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            vec++; err++;
            $display("FAIL issue_timeout cmd_ready=%b required=1", cmd_ready);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Observes cycles T, T+1, ... after acceptance until done, then one more cycle
    task automatic observe(output int n_ena, output int n_load, output int n_done,
                           output int done_idx, output int last_ena,
                           output logic [31:0] amts, output logic [63:0] ld_data);
        int overlap = 0;
        n_ena = 0; n_load = 0; n_done = 0; done_idx = -1; last_ena = -1;
        amts = '0; ld_data = '0;
        for (int k = 0; k < 40 && done_idx < 0; k++) begin
            @(negedge clk);
            if (ena && load) overlap++;
            if (ena) begin
                if (n_ena < 16) amts[2*n_ena +: 2] = amount;
                n_ena++;
                last_ena = k;
            end
            if (load) begin n_load++; ld_data = data; end
            if (done) begin n_done++; done_idx = k; end
        end
        @(negedge clk);
        if (done) n_done++;
        vec++;
        if (cmd_ready !== 1'b1) begin err++; $display("FAIL ready_after_done got=%b required=1", cmd_ready); end
        vec++;
        if (overlap !== 0) begin err++; $display("FAIL load_ena_overlap got=%0d required=0", overlap); end
    endtask

    task automatic test_reset();
        #3;
        vec++;
        if ({cmd_ready, busy, load, ena, done} !== 5'b10000) begin
            err++; $display("FAIL reset_ctrl got=%b required=10000", {cmd_ready, busy, load, ena, done});
        end
        vec++;
        if (amount !== 2'b00 || data !== 64'h0) begin
            err++; $display("FAIL reset_amount_data amount=%b data=%h required 00/0", amount, data);
        end
        @(negedge clk); @(negedge clk);
        areset = 1'b0;
    endtask

    task automatic test_load_then_shift();
        int ne, nl, nd, di, le; logic [31:0] am; logic [63:0] ldd;
        issue(1'b1, 1'b0, 6'd0, 64'h8000_0000_0000_0001);
        observe(ne, nl, nd, di, le, am, ldd);
        vec++; if (nl !== 1 || ne !== 0) begin err++; $display("FAIL load_pulses load=%0d ena=%0d required 1/0", nl, ne); end
        vec++; if (ldd !== 64'h8000_0000_0000_0001) begin err++; $display("FAIL load_data got=%h required=8000000000000001", ldd); end
        vec++; if (di !== 1 || nd !== 1) begin err++; $display("FAIL load_done idx=%0d cnt=%0d required 1/1", di, nd); end
        issue(1'b0, 1'b1, 6'd9, 64'h0);
        observe(ne, nl, nd, di, le, am, ldd);
        vec++; if (ne !== 2) begin err++; $display("FAIL sar9_ena got=%0d required=2", ne); end
        vec++; if (am[3:0] !== 4'b1011) begin err++; $display("FAIL sar9_amounts got=%b required=1011", am[3:0]); end
        vec++; if (q !== 64'hFFC0_0000_0000_0000) begin err++; $display("FAIL sar9_q got=%h required=ffc0000000000000", q); end
        vec++; if (di !== 2 || nd !== 1) begin err++; $display("FAIL sar9_done idx=%0d cnt=%0d required 2/1", di, nd); end
    endtask

    task automatic test_shift_left19();
        int ne, nl, nd, di, le; logic [31:0] am; logic [63:0] ldd;
        issue(1'b1, 1'b0, 6'd0, 64'h1);
        observe(ne, nl, nd, di, le, am, ldd);
        issue(1'b0, 1'b0, 6'd19, 64'h1);
        observe(ne, nl, nd, di, le, am, ldd);
        vec++; if (ne !== 5) begin err++; $display("FAIL shl19_ena got=%0d required=5", ne); end
        vec++; if (am[9:0] !== 10'b00_00_00_01_01) begin err++; $display("FAIL shl19_amounts got=%b required=0000000101", am[9:0]); end
        vec++; if (q !== 64'h80000) begin err++; $display("FAIL shl19_q got=%h required=80000", q); end
        vec++; if (di !== le + 1 || di !== 5) begin err++; $display("FAIL shl19_done_idx got=%0d last_ena=%0d required=5", di, le); end
    endtask

    task automatic test_boundaries();
        int ne, nl, nd, di, le; logic [31:0] am; logic [63:0] ldd;
        issue(1'b0, 1'b0, 6'd0, 64'h1);
        observe(ne, nl, nd, di, le, am, ldd);
        vec++; if (ne !== 0 || nl !== 0 || nd !== 1 || di !== 0) begin
            err++; $display("FAIL cnt0 ena=%0d load=%0d done=%0d idx=%0d required 0/0/1/0", ne, nl, nd, di);
        end
        vec++; if (q !== 64'h80000) begin err++; $display("FAIL cnt0_q got=%h required=80000", q); end
        issue(1'b1, 1'b0, 6'd0, 64'h1);
        observe(ne, nl, nd, di, le, am, ldd);
        issue(1'b0, 1'b0, 6'd63, 64'h1);
        observe(ne, nl, nd, di, le, am, ldd);
        vec++; if (ne !== 14 || di !== 14) begin err++; $display("FAIL cnt63_ena got=%0d idx=%0d required 14/14", ne, di); end
        vec++; if (q !== 64'h8000_0000_0000_0000) begin err++; $display("FAIL cnt63_q got=%h required=8000000000000000", q); end
        issue(1'b1, 1'b0, 6'd0, 64'h1);
        observe(ne, nl, nd, di, le, am, ldd);
        issue(1'b0, 1'b0, 6'd8, 64'h1);
        observe(ne, nl, nd, di, le, am, ldd);
        vec++; if (ne !== 1 || am[1:0] !== 2'b01) begin err++; $display("FAIL cnt8 ena=%0d amount=%b required 1/01", ne, am[1:0]); end
        vec++; if (q !== 64'h100) begin err++; $display("FAIL cnt8_q got=%h required=100", q); end
    endtask

    task automatic test_back_to_back();
        int ne, nl, nd, di, le; logic [31:0] am; logic [63:0] ldd;
        int ready_idx = -1, load_idx = -1, n_load = 0, n_done = 0, early_ready = 0;
        issue(1'b1, 1'b0, 6'd0, 64'h1);
        observe(ne, nl, nd, di, le, am, ldd);
        issue(1'b0, 1'b0, 6'd3, 64'h0);
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_data = 64'hDEAD_BEEF_0000_1234;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (load) begin n_load++; load_idx = k; end
            if (done) n_done++;
            if (cmd_ready && ready_idx < 0 && k < 4) early_ready++;
            if (cmd_ready && cmd_valid) begin
                ready_idx = k;
                @(posedge clk);
                #1 cmd_valid = 1'b0;
            end
        end
        vec++; if (early_ready !== 0 || ready_idx !== 4) begin err++; $display("FAIL hold_ready early=%0d idx=%0d required 0/4", early_ready, ready_idx); end
        vec++; if (n_load !== 1 || load_idx !== 5) begin err++; $display("FAIL hold_load cnt=%0d idx=%0d required 1/5", n_load, load_idx); end
        vec++; if (n_done !== 2) begin err++; $display("FAIL hold_done_cnt got=%0d required=2", n_done); end
        vec++; if (q !== 64'hDEAD_BEEF_0000_1234) begin err++; $display("FAIL hold_q got=%h required=deadbeef00001234", q); end
    endtask

    task automatic test_reset_mid_shift();
        int ne, nl, nd, di, le; logic [31:0] am; logic [63:0] ldd;
        int stray = 0;
        issue(1'b1, 1'b0, 6'd0, 64'h1);
        observe(ne, nl, nd, di, le, am, ldd);
        issue(1'b0, 1'b0, 6'd40, 64'h0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        vec++; if (ena !== 1'b1 || amount !== 2'b01) begin err++; $display("FAIL mid_third_ena ena=%b amount=%b required 1/01", ena, amount); end
        #2 areset = 1'b1;
        #1;
        vec++; if ({ena, amount, busy, done} !== 5'b00000) begin
            err++; $display("FAIL mid_async_drop got=%b required=00000", {ena, amount, busy, done});
        end
        @(posedge clk); #1 areset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done || ena || load || !cmd_ready) stray++;
        end
        vec++; if (stray !== 0) begin err++; $display("FAIL mid_after_release got=%0d bad cycles required=0", stray); end
        vec++; if (q !== 64'h10000) begin err++; $display("FAIL mid_q got=%h required=10000", q); end
        issue(1'b0, 1'b0, 6'd1, 64'h0);
        observe(ne, nl, nd, di, le, am, ldd);
        vec++; if (q !== 64'h20000 || nd !== 1) begin err++; $display("FAIL post_reset_cmd q=%h done=%0d required 20000/1", q, nd); end
    endtask

    initial begin
        test_reset();
        test_load_then_shift();
        test_shift_left19();
        test_boundaries();
        test_back_to_back();
        test_reset_mid_shift();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
